// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, state type and constant-multiply helper for the RS syndrome path.
package rs_pkg;

    // Low byte of the primitive polynomial x^8+x^4+x^3+x^2+1; the x^8 term is implicit.
    localparam logic [7:0] GF_POLY = 8'h1D;

    localparam logic [7:0] ALPHA_POW [1:6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    typedef enum logic {
        StAccum = 1'b0,
        StHold  = 1'b1
    } rs_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // With a constant c this reduces to a fixed XOR network.
    function automatic logic [7:0] gf_mul_by_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] t;
        logic [7:0] p;
        t = a;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                p = p ^ t;
            end
            t = gf_xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_mul_const.sv
// Combinational GF(2^8) multiply by the constant alpha^K, K in 1..6.
module gf_mul_const
    import rs_pkg::*;
#(
    parameter int unsigned K = 1
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);

    assign p_o = gf_mul_by_const(a_i, ALPHA_POW[K]);

endmodule

// File: rtl/rs_syndrome_gen.sv
// RS(N, N-6) syndrome generator: Horner evaluation of the received word at alpha^1..alpha^6,
// handing each syndrome set to the S_to_Sigma stage, parking it in HOLD while that stage is busy.
module rs_syndrome_gen
    import rs_pkg::*;
#(
    parameter int unsigned N = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [7:0] sym_in,
    output logic       sym_ready,
    input  logic       sigma_ready,
    output logic       signal,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic       err_flag
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    rs_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [5:0][7:0]       acc_q, acc_d;
    logic [5:0][7:0]       w_q, w_d;
    logic                  signal_q, signal_d;
    logic                  err_q, err_d;
    logic [5:0][7:0]       mul_out;
    logic [5:0][7:0]       acc_upd;
    logic                  accept;

    for (genvar j = 0; j < 6; j++) begin : g_mul
        gf_mul_const #(
            .K(j + 1)
        ) u_mul (
            .a_i(acc_q[j]),
            .p_o(mul_out[j])
        );
    end

    assign sym_ready = (state_q == StAccum);
    assign accept    = sym_valid & sym_ready;

    always_comb begin
        for (int j = 0; j < 6; j++) begin
            acc_upd[j] = mul_out[j] ^ sym_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        w_d      = w_q;
        signal_d = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        if (sigma_ready) begin
                            w_d      = acc_upd;
                            signal_d = 1'b1;
                            err_d    = |acc_upd;
                            acc_d    = '0;
                        end else begin
                            acc_d   = acc_upd;
                            state_d = StHold;
                        end
                    end else begin
                        acc_d = acc_upd;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (sigma_ready) begin
                    w_d      = acc_q;
                    signal_d = 1'b1;
                    err_d    = |acc_q;
                    acc_d    = '0;
                    state_d  = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StAccum;
            cnt_q    <= '0;
            acc_q    <= '0;
            w_q      <= '0;
            signal_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            w_q      <= w_d;
            signal_q <= signal_d;
            err_q    <= err_d;
        end
    end

    assign signal   = signal_q;
    assign err_flag = err_q;
    assign w1       = w_q[0];
    assign w2       = w_q[1];
    assign w3       = w_q[2];
    assign w4       = w_q[3];
    assign w5       = w_q[4];
    assign w6       = w_q[5];

endmodule
